// File: rtl/sin_wave_gen_if.sv
// Bus between the sine generator, its control logic and the quarter-wave sin_table ROM.
// The master side is the generator; the slave side is the control logic plus table.
interface sin_wave_gen_if #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADR_WIDTH   = 8,
  parameter int unsigned PHASE_WIDTH = 16
);
  logic                   en;
  logic                   sync;
  logic [PHASE_WIDTH-1:0] fcw;
  logic                   rd;
  logic [ADR_WIDTH-1:0]   addr;
  logic [WIDTH-1:0]       d_in;
  logic [WIDTH:0]         sample;
  logic                   sample_valid;

  modport master (
    input  en, sync, fcw, d_in,
    output rd, addr, sample, sample_valid
  );

  modport slave (
    output en, sync, fcw, d_in,
    input  rd, addr, sample, sample_valid
  );
endinterface

// File: rtl/sin_wave_gen.sv
// Full-wave sine generator: phase accumulator, quadrant-mirrored reads of a quarter-wave
// table, and sign reconstruction of the returned unsigned table data.
module sin_wave_gen #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADR_WIDTH   = 8,
  // Must be at least ADR_WIDTH+2; the bits below the table index only accumulate.
  parameter int unsigned PHASE_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  sin_wave_gen_if.master bus
);

  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   rd_q, rd_d;
  logic [ADR_WIDTH-1:0]   addr_q, addr_d;
  logic                   neg1_q, neg1_d;
  logic                   v2_q, v2_d;
  logic                   neg2_q, neg2_d;
  logic [WIDTH:0]         sample_q, sample_d;
  logic                   sample_valid_q, sample_valid_d;

  logic [1:0]             quad;
  logic [ADR_WIDTH-1:0]   idx;
  logic [ADR_WIDTH-1:0]   mapped;
  logic [WIDTH:0]         mag;

  assign quad   = phase_q[PHASE_WIDTH-1 -: 2];
  assign idx    = phase_q[PHASE_WIDTH-3 -: ADR_WIDTH];
  // Odd quadrants walk the quarter-wave table backwards.
  assign mapped = quad[0] ? ~idx : idx;
  assign mag    = {1'b0, bus.d_in};

  // Stage 0: phase accumulation and table read issue; sync wins over en.
  always_comb begin
    phase_d = phase_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    neg1_d  = neg1_q;
    if (bus.sync) begin
      phase_d = '0;
    end else if (bus.en) begin
      addr_d  = mapped;
      rd_d    = 1'b1;
      neg1_d  = quad[1];
      phase_d = phase_q + bus.fcw;
    end
  end

  // Stages 1 and 2: track the read through the table latency, then apply the sign.
  always_comb begin
    v2_d           = rd_q;
    neg2_d         = neg1_q;
    sample_valid_d = v2_q;
    sample_d       = sample_q;
    if (v2_q) begin
      // Zero-extended magnitude cannot overflow when negated; -0 stays 0.
      sample_d = neg2_q ? (~mag + 1'b1) : mag;
    end
  end

  // State registers with asynchronous reset; reset discards reads in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q        <= '0;
      rd_q           <= 1'b0;
      addr_q         <= '0;
      neg1_q         <= 1'b0;
      v2_q           <= 1'b0;
      neg2_q         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      rd_q           <= rd_d;
      addr_q         <= addr_d;
      neg1_q         <= neg1_d;
      v2_q           <= v2_d;
      neg2_q         <= neg2_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign bus.rd           = rd_q;
  assign bus.addr         = addr_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_sin_wave_gen.sv
// Self-checking bench for sin_wave_gen with a behavioural sin_table and sample model.
module tb_sin_wave_gen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sin_wave_gen_if #(.WIDTH(8), .ADR_WIDTH(8), .PHASE_WIDTH(16)) bus ();

  sin_wave_gen #(.WIDTH(8), .ADR_WIDTH(8), .PHASE_WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quarter-wave table contents and its registered read port.
  logic [7:0] tbl [256];
  initial begin
    for (int a = 0; a < 256; a++) begin
      tbl[a] = 8'($rtoi(255.0 * $sin(3.14159265358979 * a / 510.0) + 0.5));
    end
  end
  initial bus.d_in = '0;
  always @(posedge clk) if (bus.rd) bus.d_in <= tbl[bus.addr];

  // Reference model: accepted requests travel down a two-slot delay line.
  logic [15:0] m_phase;
  logic        m_rd;
  logic [7:0]  m_addr;
  logic        m_p0v, m_p1v, m_sv;
  logic [8:0]  m_p0s, m_p1s, m_s;

  function automatic logic [7:0] ref_addr(input logic [15:0] ph);
    int unsigned qd, ix;
    qd = ph / 16384;
    ix = (ph / 64) % 256;
    if (qd % 2 == 1) ix = 255 - ix;
    return 8'(ix);
  endfunction

  function automatic logic [8:0] ref_sample(input logic [15:0] ph);
    int mag;
    mag = int'(tbl[ref_addr(ph)]);
    return (ph >= 16'h8000) ? 9'(-mag) : 9'(mag);
  endfunction

  task automatic model_clear();
    m_phase = '0; m_rd = 1'b0; m_addr = '0;
    m_p0v = 1'b0; m_p1v = 1'b0; m_sv = 1'b0;
    m_p0s = '0; m_p1s = '0; m_s = '0;
  endtask

  // Apply en/sync for one edge, advance the model, and return 1 time unit after the edge.
  task automatic tick(input logic e, input logic s);
    bus.en = e;
    bus.sync = s;
    @(posedge clk);
    m_sv = m_p1v;
    if (m_p1v) m_s = m_p1s;
    m_p1v = m_p0v;
    m_p1s = m_p0s;
    if (s) begin
      m_phase = '0; m_rd = 1'b0; m_p0v = 1'b0;
    end else if (e) begin
      m_addr = ref_addr(m_phase);
      m_p0s = ref_sample(m_phase);
      m_rd = 1'b1; m_p0v = 1'b1;
      m_phase = m_phase + bus.fcw;
    end else begin
      m_rd = 1'b0; m_p0v = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.sync = 1'b0; bus.fcw = 16'h0123;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.rd, bus.addr, bus.sample, bus.sample_valid} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_por: got rd=%b addr=%h sample=%h sv=%b required all 0",
               bus.rd, bus.addr, bus.sample, bus.sample_valid);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if ({bus.rd, bus.addr, bus.sample_valid, bus.sample} !== {m_rd, m_addr, m_sv, m_s}) begin
        n_fail++;
        $display("FAIL reset_stream[%0d]: got %h required %h", k,
                 {bus.rd, bus.addr, bus.sample_valid, bus.sample}, {m_rd, m_addr, m_sv, m_s});
      end
    end
    // Two reads are in flight here; reset mid-cycle must clear outputs at once.
    rst = 1'b1;
    #2;
    n_checks++;
    if ({bus.rd, bus.addr, bus.sample, bus.sample_valid} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_async: got rd=%b addr=%h sample=%h sv=%b required all 0",
               bus.rd, bus.addr, bus.sample, bus.sample_valid);
    end
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b0);
      n_checks++;
      if (bus.sample_valid !== 1'b0 || bus.rd !== 1'b0 || bus.sample !== 9'h0) begin
        n_fail++;
        $display("FAIL reset_flush[%0d]: got sv=%b rd=%b sample=%h required 0 0 000", k,
                 bus.sample_valid, bus.rd, bus.sample);
      end
    end
  endtask

  task automatic test_latency();
    tick(1'b0, 1'b1);
    bus.fcw = 16'h4000;
    tick(1'b1, 1'b0);
    n_checks++;
    if (bus.rd !== 1'b1 || bus.addr !== 8'd0) begin
      n_fail++;
      $display("FAIL latency_issue: got rd=%b addr=%0d required 1 0", bus.rd, bus.addr);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (bus.rd !== 1'b0 || bus.sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n1: got rd=%b sv=%b required 0 0", bus.rd, bus.sample_valid);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (bus.sample_valid !== 1'b1 || bus.sample !== 9'h000) begin
      n_fail++;
      $display("FAIL latency_n2: got sv=%b sample=%h required 1 000",
               bus.sample_valid, bus.sample);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (bus.sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n3: got sv=%b required 0", bus.sample_valid);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (bus.rd !== 1'b1 || bus.addr !== 8'd255) begin
      n_fail++;
      $display("FAIL latency_q1_addr: got rd=%b addr=%0d required 1 255", bus.rd, bus.addr);
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_checks++;
    if (bus.sample_valid !== 1'b1 || bus.sample !== {1'b0, tbl[255]} || bus.sample !== m_s) begin
      n_fail++;
      $display("FAIL latency_peak: got sv=%b sample=%h required 1 %h",
               bus.sample_valid, bus.sample, {1'b0, tbl[255]});
    end
  endtask

  task automatic test_full_period();
    int unsigned seg, off;
    tick(1'b0, 1'b1);
    bus.fcw = 16'h0040;
    for (int k = 0; k < 2050; k++) begin
      tick(k < 2048, 1'b0);
      if (k < 2048) begin
        seg = (k / 256) % 2;
        off = k % 256;
        n_checks++;
        if (bus.rd !== 1'b1 || bus.addr !== 8'(seg == 1 ? 255 - off : off)) begin
          n_fail++;
          $display("FAIL full_addr[%0d]: got rd=%b addr=%0d required 1 %0d", k, bus.rd,
                   bus.addr, (seg == 1 ? 255 - off : off));
        end
      end
      n_checks++;
      if ({bus.sample_valid, bus.sample} !== {m_sv, m_s}) begin
        n_fail++;
        $display("FAIL full_sample[%0d]: got sv=%b sample=%h required %b %h", k,
                 bus.sample_valid, bus.sample, m_sv, m_s);
      end
    end
  endtask

  task automatic test_negation();
    tick(1'b0, 1'b1);
    bus.fcw = 16'h8040;
    tick(1'b1, 1'b0);
    n_checks++;
    if (bus.addr !== 8'd0) begin
      n_fail++;
      $display("FAIL neg_addr0: got %0d required 0", bus.addr);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (bus.addr !== 8'd1) begin
      n_fail++;
      $display("FAIL neg_addr1: got %0d required 1", bus.addr);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (bus.sample_valid !== 1'b1 || bus.sample !== 9'h000) begin
      n_fail++;
      $display("FAIL neg_s0: got sv=%b sample=%h required 1 000", bus.sample_valid, bus.sample);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (bus.sample_valid !== 1'b1 || bus.sample !== 9'h1FE || bus.sample !== m_s) begin
      n_fail++;
      $display("FAIL neg_s1: got sv=%b sample=%h required 1 1fe", bus.sample_valid, bus.sample);
    end
  endtask

  task automatic test_stall_priority();
    logic [1:0] pat [7];
    pat = '{2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00};
    tick(1'b0, 1'b1);
    bus.fcw = 16'h0040;
    for (int k = 0; k < 7; k++) begin
      tick(pat[k][1], pat[k][0]);
      n_checks++;
      if ({bus.rd, bus.addr, bus.sample_valid, bus.sample} !== {m_rd, m_addr, m_sv, m_s}) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %h required %h", k,
                 {bus.rd, bus.addr, bus.sample_valid, bus.sample}, {m_rd, m_addr, m_sv, m_s});
      end
      if (k == 3) begin
        n_checks++;
        if (bus.rd !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_sync_rd: got rd=%b required 0", bus.rd);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (bus.rd !== 1'b1 || bus.addr !== 8'd0) begin
          n_fail++;
          $display("FAIL stall_after_sync: got rd=%b addr=%0d required 1 0", bus.rd, bus.addr);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) bus.fcw = 16'($urandom);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      n_checks++;
      if ({bus.rd, bus.addr, bus.sample_valid, bus.sample} !== {m_rd, m_addr, m_sv, m_s}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h required %h", k,
                 {bus.rd, bus.addr, bus.sample_valid, bus.sample}, {m_rd, m_addr, m_sv, m_s});
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_latency();
    test_full_period();
    test_negation();
    test_stall_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
